// File: rtl/divider_pkg.sv
// Shared widths, counter width and FSM state encoding for the divider recompose block.
package divider_pkg;

  localparam int unsigned QW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 16;
  localparam int unsigned AW = NW + 1;
  localparam int unsigned CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_recompose_mul_if.sv
// Producer/consumer handshake bundle for divider_recompose_mul.
// The n_ref/err_abs/err_flag signals exist only when DIV_ERR_CHECK_EN is defined.
interface divider_recompose_mul_if;
  import divider_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] q;
  logic [DW-1:0] d;
  logic [QW-1:0] r;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] n_out;
`ifdef DIV_ERR_CHECK_EN
  logic [NW-1:0] n_ref;
  logic [NW-1:0] err_abs;
  logic          err_flag;

  modport master (output in_valid, q, d, r, n_ref, out_ready,
                  input  in_ready, out_valid, n_out, err_abs, err_flag);
  modport slave  (input  in_valid, q, d, r, n_ref, out_ready,
                  output in_ready, out_valid, n_out, err_abs, err_flag);
`else
  modport master (output in_valid, q, d, r, out_ready,
                  input  in_ready, out_valid, n_out);
  modport slave  (input  in_valid, q, d, r, out_ready,
                  output in_ready, out_valid, n_out);
`endif

endinterface

// File: rtl/recompose_abs_diff.sv
// Combinational NW-bit absolute difference |a-b| with a nonzero indicator.
module recompose_abs_diff
  import divider_pkg::*;
(
  input  logic [NW-1:0] a_i,
  input  logic [NW-1:0] b_i,
  output logic [NW-1:0] abs_c_o,
  output logic          nonzero_c_o
);

  always_comb begin
    abs_c_o     = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    nonzero_c_o = (a_i != b_i);
  end

endmodule

// File: rtl/divider_recompose_mul.sv
// Sequential shift-add recomposer n_out = q*d + r, one partial product per cycle.
// Optional DIV_ERR_CHECK_EN adds the compare against the original dividend.
module divider_recompose_mul
  import divider_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  divider_recompose_mul_if.slave  bus_io
);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [NW-1:0] d_sh_q, d_sh_d;
  logic [QW-1:0] q_sh_q, q_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [NW-1:0] n_out_q, n_out_d;
  logic [AW-1:0] acc_step_c;

`ifdef DIV_ERR_CHECK_EN
  logic [NW-1:0] n_ref_q, n_ref_d;
  logic          range_err_q, range_err_d;
  logic [NW-1:0] err_abs_q, err_abs_d;
  logic          err_flag_q, err_flag_d;
  logic [NW-1:0] abs_c;
  logic          nonzero_c;

  // Compare uses the post-step accumulator so the result is ready on the MUL->DONE edge.
  recompose_abs_diff u_abs_diff (
    .a_i         (n_ref_q),
    .b_i         (acc_step_c[NW-1:0]),
    .abs_c_o     (abs_c),
    .nonzero_c_o (nonzero_c)
  );
`endif

  assign acc_step_c = acc_q + (q_sh_q[0] ? AW'(d_sh_q) : AW'(0));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    d_sh_d      = d_sh_q;
    q_sh_d      = q_sh_q;
    cnt_d       = cnt_q;
    n_out_d     = n_out_q;
`ifdef DIV_ERR_CHECK_EN
    n_ref_d     = n_ref_q;
    range_err_d = range_err_q;
    err_abs_d   = err_abs_q;
    err_flag_d  = err_flag_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          acc_d   = AW'(bus_io.r);
          d_sh_d  = NW'(bus_io.d);
          q_sh_d  = bus_io.q;
          cnt_d   = '0;
          state_d = MUL;
`ifdef DIV_ERR_CHECK_EN
          n_ref_d     = bus_io.n_ref;
          range_err_d = (bus_io.d != '0) && (DW'(bus_io.r) >= bus_io.d);
`endif
        end
      end
      MUL: begin
        acc_d  = acc_step_c;
        d_sh_d = d_sh_q << 1;
        q_sh_d = q_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) begin
          state_d = DONE;
          n_out_d = acc_step_c[NW-1:0];
`ifdef DIV_ERR_CHECK_EN
          err_abs_d  = abs_c;
          err_flag_d = nonzero_c | range_err_q;
`endif
        end
      end
      DONE: begin
        if (bus_io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      d_sh_q      <= '0;
      q_sh_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      n_out_q     <= '0;
`ifdef DIV_ERR_CHECK_EN
      n_ref_q     <= '0;
      range_err_q <= 1'b0;
      err_abs_q   <= '0;
      err_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      d_sh_q      <= d_sh_d;
      q_sh_q      <= q_sh_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      n_out_q     <= n_out_d;
`ifdef DIV_ERR_CHECK_EN
      n_ref_q     <= n_ref_d;
      range_err_q <= range_err_d;
      err_abs_q   <= err_abs_d;
      err_flag_q  <= err_flag_d;
`endif
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.n_out     = n_out_q;
`ifdef DIV_ERR_CHECK_EN
  assign bus_io.err_abs   = err_abs_q;
  assign bus_io.err_flag  = err_flag_q;
`endif

  // 255*255+255 fits in NW bits, so the carry bit must never be reached.
  acc_no_overflow_a: assert property (@(posedge clk) disable iff (rst) !acc_q[NW]);

endmodule
